// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues one outstanding I-cache read per fetch and loads the IF/ID register.
// Handles pipeline stall/flush, and drops responses that belong to flushed fetches.
module if_fetch_stage #(
  parameter int                   XLEN     = 64,
  parameter int                   ILEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = 'h8000_0000,
  parameter logic [ILEN-1:0]      NOP_INST = 'h0000_0013,
  parameter int                   CTRL_IF  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_next_i,
  input  logic            read_req_i,
  input  logic [5:0]      stall_valid_i,
  input  logic [5:0]      flush_valid_i,
  output logic            ic_req_o,
  output logic [XLEN-1:0] ic_addr_o,
  input  logic            ic_ready_i,
  input  logic            ic_rvalid_i,
  input  logic [ILEN-1:0] ic_rdata_i,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o,
  output logic            stallreq_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [ILEN-1:0] buf_inst_q, buf_inst_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  logic            stall_if;
  logic            flush_if;
  logic            req_issue;
  logic            wr_en;
  logic [ILEN-1:0] wr_inst;

  assign stall_if  = stall_valid_i[CTRL_IF];
  assign flush_if  = flush_valid_i[CTRL_IF];
  // A flush in the same cycle cancels a new request before it reaches the cache.
  assign req_issue = (state_q == S_IDLE) && read_req_i && !flush_if;

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    buf_inst_d = buf_inst_q;
    ic_req_o   = req_issue;
    ic_addr_o  = req_pc_q;
    stallreq_o = 1'b0;
    wr_en      = 1'b0;
    wr_inst    = ic_rdata_i;

    case (state_q)
      S_IDLE: begin
        ic_addr_o  = pc_next_i;
        stallreq_o = req_issue && !ic_ready_i;
        if (req_issue && ic_ready_i) begin
          req_pc_d = pc_next_i;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        stallreq_o = 1'b1;
        if (ic_rvalid_i) begin
          if (flush_if) begin
            state_d = S_IDLE;
          end else if (stall_if) begin
            buf_inst_d = ic_rdata_i;
            state_d    = S_HOLD;
          end else begin
            wr_en   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (flush_if) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        stallreq_o = 1'b1;
        if (ic_rvalid_i) begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        wr_inst = buf_inst_q;
        if (flush_if) begin
          state_d = S_IDLE;
        end else if (!stall_if) begin
          wr_en   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // IF/ID register: flush beats stall, stall beats a new entry, otherwise a bubble.
  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_if) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else if (stall_if) begin
      valid_d = valid_q;
    end else if (wr_en) begin
      valid_d = 1'b1;
      inst_d  = wr_inst;
      pc_d    = req_pc_q;
    end else begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_pc_q   <= '0;
      buf_inst_q <= '0;
      inst_q     <= NOP_INST;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      buf_inst_q <= buf_inst_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized fetch transactions against a transaction-level model; a negedge monitor checks IF/ID writes.
`timescale 1ns/1ps
module tb_if_fetch_stage;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_next_i;
  logic        read_req_i;
  logic [5:0]  stall_valid_i;
  logic [5:0]  flush_valid_i;
  logic        ic_req_o;
  logic [63:0] ic_addr_o;
  logic        ic_ready_i;
  logic        ic_rvalid_i;
  logic [31:0] ic_rdata_i;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        valid_o;
  logic        stallreq_o;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .pc_next_i(pc_next_i), .read_req_i(read_req_i),
    .stall_valid_i(stall_valid_i), .flush_valid_i(flush_valid_i),
    .ic_req_o(ic_req_o), .ic_addr_o(ic_addr_o), .ic_ready_i(ic_ready_i),
    .ic_rvalid_i(ic_rvalid_i), .ic_rdata_i(ic_rdata_i),
    .inst_o(inst_o), .pc_o(pc_o), .valid_o(valid_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Only bit 1 is the IF stage; other bits carry noise the stage must ignore.
  task automatic ctrl(input bit s, input bit f);
    stall_valid_i = (6'($urandom) & 6'b111101) | {4'b0, s, 1'b0};
    flush_valid_i = (6'($urandom) & 6'b111101) | {4'b0, f, 1'b0};
  endtask

  // mode: 0 delivered, 1 flush before response, 2 flush with response, 3 flush while held
  task automatic fetch(input logic [63:0] pc, input logic [31:0] data,
                       input int d, input int lat, input int mode, input int h);
    read_req_i = 1'b1; pc_next_i = pc; ic_ready_i = 1'b0; ctrl(0, 0);
    for (int i = 0; i < d; i++) begin
      #1;
      check("ready_wait_req", ic_req_o, 1);
      check("ready_wait_stallreq", stallreq_o, 1);
      check("ready_wait_addr", ic_addr_o, pc);
      @(posedge clk); #1;
      ctrl(0, 0);
    end
    ic_ready_i = 1'b1;
    #1;
    check("accept_req", ic_req_o, 1);
    check("accept_stallreq", stallreq_o, 0);
    check("accept_addr", ic_addr_o, pc);
    @(posedge clk); #1;
    // Busy: whatever the PC register asks, no second request may issue.
    for (int i = 0; i < lat - 1; i++) begin
      read_req_i = 1'($urandom); pc_next_i = {$urandom, $urandom}; ic_ready_i = 1'($urandom);
      ctrl(0, (mode == 1) && (i == 0));
      #1;
      check("busy_req", ic_req_o, 0);
      check("busy_stallreq", stallreq_o, 1);
      @(posedge clk); #1;
    end
    read_req_i = 1'($urandom); ic_ready_i = 1'($urandom);
    ic_rvalid_i = 1'b1; ic_rdata_i = data;
    if (mode == 2) ctrl(1'($urandom), 1);
    else if (h > 0 && mode != 1) ctrl(1, 0);
    else ctrl(0, 0);
    if (mode == 0) exp_q.push_back('{inst: data, pc: pc});
    #1;
    check("resp_req", ic_req_o, 0);
    check("resp_stallreq", stallreq_o, 1);
    @(posedge clk); #1;
    ic_rvalid_i = 1'b0; ic_rdata_i = $urandom; read_req_i = 1'b0; ctrl(0, 0);
    if (h > 0 && (mode == 0 || mode == 3)) begin
      for (int i = 0; i < h; i++) begin
        if (i == h - 1) ctrl((mode == 3) ? 1'($urandom) : 1'b0, mode == 3);
        else ctrl(1, 0);
        read_req_i = 1'($urandom);
        #1;
        check("hold_stallreq", stallreq_o, 0);
        check("hold_req", ic_req_o, 0);
        check("hold_ifid_unchanged", valid_o, 0);
        @(posedge clk); #1;
      end
      read_req_i = 1'b0; ctrl(0, 0);
    end
    #1;
    check("done_stallreq", stallreq_o, 0);
    if (mode == 0) begin
      check("write_valid", valid_o, 1);
      check("write_inst", inst_o, data);
      check("write_pc", pc_o, pc);
    end else begin
      check("drop_valid", valid_o, 0);
      check("drop_inst", inst_o, NOP);
    end
  endtask

  // Idle cycles: flushed requests must not issue; stray responses must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      read_req_i = 1'($urandom); pc_next_i = {$urandom, $urandom};
      ic_rvalid_i = 1'($urandom); ic_rdata_i = 32'hDEAD_0000 | 32'($urandom_range(0, 255));
      ctrl(0, read_req_i);
      ic_ready_i = 1'($urandom);
      #1;
      check("idle_req", ic_req_o, 0);
      check("idle_stallreq", stallreq_o, 0);
    end
    @(posedge clk); #1;
    read_req_i = 1'b0; ic_rvalid_i = 1'b0; ctrl(0, 0);
  endtask

  initial begin : monitor
    bit stall_prev;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (valid_o && !stall_prev) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_entry: got inst %h pc %h, expected no entry", inst_o, pc_o);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_inst", inst_o, e.inst);
            check("sb_pc", pc_o, e.pc);
          end
        end
        if (!valid_o) check("bubble_nop", inst_o, NOP);
        stall_prev = stall_valid_i[1] && !flush_valid_i[1];
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; pc_next_i = '0; read_req_i = 1'b0; ic_ready_i = 1'b0;
    ic_rvalid_i = 1'b0; ic_rdata_i = '0; stall_valid_i = '0; flush_valid_i = '0;
    #12;
    check("rst_valid", valid_o, 0);
    check("rst_inst", inst_o, NOP);
    check("rst_pc", pc_o, RESET_PC);
    check("rst_req", ic_req_o, 0);
    check("rst_stallreq", stallreq_o, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    fetch(64'h8000_0000, 32'h0010_0093, 0, 1, 0, 0);
    fetch(64'h8000_0004, 32'h0020_0113, 3, 1, 0, 0);
    fetch(64'h8000_0004, 32'hDEAD_BEEF, 0, 3, 1, 0);
    fetch(64'h8000_0008, 32'h0030_0193, 0, 1, 0, 2);
    fetch(64'h8000_000C, 32'hCAFE_F00D, 0, 1, 2, 0);
    idle(2);

    for (int t = 0; t < 60; t++) begin
      int mode, lat, h, d;
      mode = $urandom_range(0, 3);
      lat  = (mode == 1) ? $urandom_range(2, 3) : $urandom_range(1, 3);
      h    = (mode == 3) ? $urandom_range(1, 2) : ((mode == 0) ? $urandom_range(0, 2) : 0);
      d    = $urandom_range(0, 2);
      fetch({$urandom, $urandom} & ~64'h3, $urandom, d, lat, mode, h);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    // Reset in the middle of an outstanding fetch, then a stale response.
    read_req_i = 1'b1; pc_next_i = 64'h8000_0100; ic_ready_i = 1'b1; ctrl(0, 0);
    @(posedge clk); #1;
    read_req_i = 1'b0; ic_ready_i = 1'b0;
    #1;
    check("pre_rst_stallreq", stallreq_o, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_inst", inst_o, NOP);
    check("mid_rst_pc", pc_o, RESET_PC);
    check("mid_rst_stallreq", stallreq_o, 0);
    check("mid_rst_req", ic_req_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; ic_rvalid_i = 1'b1; ic_rdata_i = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    ic_rvalid_i = 1'b0;
    #1;
    check("stale_stallreq", stallreq_o, 0);
    check("stale_valid", valid_o, 0);
    check("stale_pc", pc_o, RESET_PC);
    fetch(64'h8000_0200, 32'h0040_0213, 1, 2, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
